// File: rtl/exec_unit_mc.sv
// -----------------------------------------------------------------------------
// exec_unit_mc
// Multi-cycle execute stage. Accepts one decoded instruction per valid/ready
// handshake and executes an ALU, move/shift, load/store or branch operation.
// Results come back as a registered writeback bundle, registered CPSR flags and
// a branch resolution. Load/store use a request/acknowledge memory port, so the
// memory may take any number of cycles, bounded by an optional timeout.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        instruction handshake (ready only while idle)
//   first_ld, special_enc,     decoded instruction class and opcode fields
//   second_ld, alu_oc, b_cond
//   dest_reg, op1, op2,        destination index, operands, immediate,
//   imm, offset, pc            branch offset and instruction address
//   out_valid                  one-cycle result strobe
//   wb_en, wb_sel, wb_reg,     register writeback bundle (qualified by
//   wb_data                    out_valid; wb_sel 0 = ALU, 1 = memory)
//   flags                      CPSR {N,C,Z,V}
//   br_taken, br_target        branch resolution (qualified by out_valid)
//   mem_req, mem_we, mem_addr, data-memory request side
//   mem_wdata
//   mem_rdata, mem_ack         data-memory response side
//   mem_err                    sticky memory-timeout flag
// -----------------------------------------------------------------------------
module exec_unit_mc #(
    parameter int DATA_W      = 32,
    parameter int IMM_W       = 16,
    parameter int REG_AW      = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        first_ld,
    input  logic              special_enc,
    input  logic [3:0]        second_ld,
    input  logic [2:0]        alu_oc,
    input  logic [3:0]        b_cond,
    input  logic [REG_AW-1:0] dest_reg,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [IMM_W-1:0]  imm,
    input  logic [IMM_W-1:0]  offset,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    output logic              wb_en,
    output logic              wb_sel,
    output logic [REG_AW-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] CLS_MOVE   = 2'b00;
    localparam logic [1:0] CLS_MEM    = 2'b10;
    localparam logic [1:0] CLS_BRANCH = 2'b11;
    localparam logic [3:0] MEM_LOAD   = 4'b0000;
    localparam logic [3:0] MEM_STORE  = 4'b0001;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;

    localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    // Masks for the immediate field placed in the low or high end of a word.
    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'({IMM_W{1'b1}});
    localparam logic [DATA_W-1:0] HI_MASK = LO_MASK << (DATA_W - IMM_W);

    function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] v);
        return DATA_W'($signed(v));
    endfunction

    // Condition evaluation against {N,C,Z,V}.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, cf, z, v, hi, ge, gt;
        n  = f[3];
        cf = f[2];
        z  = f[1];
        v  = f[0];
        hi = cf & ~z;
        ge = (n == v);
        gt = ~z & ge;
        case (c)
            4'h0:    return z;
            4'h1:    return ~z;
            4'h2:    return cf;
            4'h3:    return ~cf;
            4'h4:    return n;
            4'h5:    return ~n;
            4'h6:    return v;
            4'h7:    return ~v;
            4'h8:    return hi;
            4'h9:    return ~hi;
            4'hA:    return ge;
            4'hB:    return ~ge;
            4'hC:    return gt;
            4'hD:    return ~gt;
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                wb_en_q, wb_en_d;
    logic                wb_sel_q, wb_sel_d;
    logic [REG_AW-1:0]   wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [3:0]          flags_q, flags_d;
    logic                br_taken_q, br_taken_d;
    logic [DATA_W-1:0]   br_target_q, br_target_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_err_q, mem_err_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    // ---------------------------------------------------------------- ALU
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ok, alu_c, alu_v;
    logic [3:0]        alu_flags;

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_b    = first_ld[0] ? op2 : sext(imm);
        alu_wide = '0;
        alu_ok   = 1'b1;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (alu_oc)
            OP_ADD:  alu_wide = {1'b0, op1} + {1'b0, alu_b};
            OP_SUB:  alu_wide = {1'b0, op1} + {1'b0, ~alu_b} + (DATA_W+1)'(1);
            3'b011:  alu_wide = {1'b0, op1 & alu_b};
            3'b100:  alu_wide = {1'b0, op1 | alu_b};
            3'b101:  alu_wide = {1'b0, op1 ^ alu_b};
            3'b110:  alu_wide = {1'b0, ~op1};
            default: alu_ok = 1'b0;
        endcase
        alu_res = alu_wide[DATA_W-1:0];
        // Carry is the bit above the word; for SUB it reads as "no borrow".
        // Overflow: operands of the effective addition share a sign that
        // the result does not.
        if (alu_oc == OP_ADD) begin
            alu_c = alu_wide[DATA_W];
            alu_v = (op1[DATA_W-1] == alu_b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != op1[DATA_W-1]);
        end else if (alu_oc == OP_SUB) begin
            alu_c = alu_wide[DATA_W];
            alu_v = (op1[DATA_W-1] != alu_b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != op1[DATA_W-1]);
        end
        alu_flags = {alu_res[DATA_W-1], alu_c, (alu_res == '0), alu_v};
    end

    // ---------------------------------------------------------- move/shift
    logic [DATA_W-1:0] mv_res;
    logic              mv_ok;
    logic              shamt_big;
    logic [DATA_W-1:0] imm_z;

    always_comb begin
        imm_z     = DATA_W'(imm);
        shamt_big = (int'(imm) >= DATA_W);
        mv_ok     = 1'b1;
        mv_res    = '0;
        case (alu_oc)
            3'b000:  mv_res = (op1 & ~LO_MASK) | imm_z;
            3'b001:  mv_res = (op1 & ~HI_MASK) | (imm_z << (DATA_W - IMM_W));
            3'b010:  mv_res = '0;
            3'b011:  mv_res = '1;
            3'b100:  mv_res = shamt_big ? '0 : (op1 << imm);
            3'b101:  mv_res = shamt_big ? '0 : (op1 >> imm);
            default: mv_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------ next state
    logic timeout;
    assign timeout = (MEM_TIMEOUT != 0) && (timer_q == TMR_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        wb_en_d     = wb_en_q;
        wb_sel_d    = wb_sel_q;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        flags_d     = flags_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = mem_err_q;
        timer_d     = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    wb_reg_d    = dest_reg;
                    wb_en_d     = 1'b0;
                    wb_sel_d    = 1'b0;
                    br_taken_d  = 1'b0;
                    br_target_d = pc + sext(offset);
                    timer_d     = '0;
                    state_d     = ST_RESP;
                    if (first_ld == CLS_MEM) begin
                        wb_sel_d = 1'b1;
                        if (second_ld == MEM_LOAD) begin
                            mem_we_d   = 1'b0;
                            mem_addr_d = op1 + sext(imm);
                            state_d    = ST_MEM;
                        end else if (second_ld == MEM_STORE) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = op2 + sext(imm);
                            mem_wdata_d = op1;
                            state_d     = ST_MEM;
                        end
                    end else if (first_ld == CLS_BRANCH) begin
                        // Flags as they stand at acceptance decide the branch.
                        br_taken_d = cond_pass(b_cond, flags_q);
                    end else if (special_enc) begin
                        wb_data_d = alu_res;
                        wb_en_d   = alu_ok;
                        if (second_ld[3] && alu_ok) flags_d = alu_flags;
                    end else if (first_ld == CLS_MOVE) begin
                        wb_data_d = mv_res;
                        wb_en_d   = mv_ok;
                    end
                end
            end
            ST_MEM: begin
                // An ack in the last allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d = ST_RESP;
                    if (!mem_we_q) begin
                        wb_data_d = mem_rdata;
                        wb_en_d   = 1'b1;
                    end
                end else if (timeout) begin
                    state_d   = ST_RESP;
                    mem_err_d = 1'b1;
                    wb_en_d   = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready_d = (state_d == ST_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_sel_q    <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            flags_q     <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            wb_en_q     <= wb_en_d;
            wb_sel_q    <= wb_sel_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            flags_q     <= flags_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_err_q   <= mem_err_d;
            timer_q     <= timer_d;
        end
    end

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops mem_req and out_valid immediately.
    assign out_valid = (state_q == ST_RESP);
    assign mem_req   = (state_q == ST_MEM);
    assign in_ready  = in_ready_q;
    assign wb_en     = wb_en_q;
    assign wb_sel    = wb_sel_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;
    assign flags     = flags_q;
    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_exec_unit_mc
// Directed bench for exec_unit_mc: a table of single-instruction vectors with
// hand-computed results (flags carry over between rows), then hand-written
// sequences for a delayed-ack load, a store timeout and a reset mid-load.
// -----------------------------------------------------------------------------
module tb_exec_unit_mc;

    localparam int DW  = 32;
    localparam int IW  = 16;
    localparam int AW  = 3;
    localparam int TMO = 4;
    localparam int NV  = 30;

    typedef struct {
        logic [1:0]    fl;
        logic          se;
        logic [3:0]    sl;
        logic [2:0]    oc;
        logic [3:0]    bc;
        logic [AW-1:0] rd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [IW-1:0] im;
        logic [IW-1:0] of;
        logic [DW-1:0] pc;
        logic          e_wen;
        logic [DW-1:0] e_data;
        logic [3:0]    e_flags;
        logic          e_bt;
        logic [DW-1:0] e_btgt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    first_ld = '0;
    logic          special_enc = 1'b0;
    logic [3:0]    second_ld = '0;
    logic [2:0]    alu_oc = '0;
    logic [3:0]    b_cond = '0;
    logic [AW-1:0] dest_reg = '0;
    logic [DW-1:0] op1 = '0, op2 = '0, pc = '0;
    logic [IW-1:0] imm = '0, offset = '0;
    logic          out_valid, wb_en, wb_sel, br_taken;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data, br_target;
    logic [3:0]    flags;
    logic          mem_req, mem_we, mem_err;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_unit_mc #(
        .DATA_W(DW), .IMM_W(IW), .REG_AW(AW), .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .first_ld(first_ld), .special_enc(special_enc), .second_ld(second_ld),
        .alu_oc(alu_oc), .b_cond(b_cond), .dest_reg(dest_reg),
        .op1(op1), .op2(op2), .imm(imm), .offset(offset), .pc(pc),
        .out_valid(out_valid), .wb_en(wb_en), .wb_sel(wb_sel), .wb_reg(wb_reg),
        .wb_data(wb_data), .flags(flags), .br_taken(br_taken),
        .br_target(br_target),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_err(mem_err)
    );

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        first_ld    = v.fl;
        special_enc = v.se;
        second_ld   = v.sl;
        alu_oc      = v.oc;
        b_cond      = v.bc;
        dest_reg    = v.rd;
        op1         = v.a;
        op2         = v.b;
        imm         = v.im;
        offset      = v.of;
        pc          = v.pc;
        in_valid    = 1'b1;
    endtask

    // Drive at a falling edge, wait (bounded) for in_ready, let the rising
    // edge accept, and return #1 after that edge.
    task automatic issue(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        drive(v);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check1({tag, " ready_wait"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        issue(v, t);
        check1({t, " out_valid"}, out_valid, 1'b1);
        check1({t, " wb_en"}, wb_en, v.e_wen);
        if (v.e_wen) begin
            check32({t, " wb_data"}, wb_data, v.e_data);
            check32({t, " wb_reg"}, 32'(wb_reg), 32'(v.rd));
        end
        check32({t, " flags"}, 32'(flags), 32'(v.e_flags));
        check1({t, " br_taken"}, br_taken, v.e_bt);
        if (v.fl == 2'b11) check32({t, " br_target"}, br_target, v.e_btgt);
    endtask

    vec_t vecs[NV];

    initial begin
        // fl se sl oc bc rd a b im of pc | wen data flags bt btgt
        vecs[0]  = '{2'b01,1'b1,4'h8,3'd1,4'h0,3'd1,32'h7FFFFFFF,32'h1,16'h0,16'h0,32'h0, 1'b1,32'h80000000,4'b1001,1'b0,32'h0};
        vecs[1]  = '{2'b00,1'b1,4'h8,3'd2,4'h0,3'd2,32'h5,32'h0,16'h0005,16'h0,32'h0, 1'b1,32'h0,4'b0110,1'b0,32'h0};
        vecs[2]  = '{2'b11,1'b0,4'h0,3'd0,4'h0,3'd0,32'h0,32'h0,16'h0,16'hFFFC,32'h100, 1'b0,32'h0,4'b0110,1'b1,32'hFC};
        vecs[3]  = '{2'b11,1'b0,4'h0,3'd0,4'h1,3'd0,32'h0,32'h0,16'h0,16'h0020,32'hFFFFFFF0, 1'b0,32'h0,4'b0110,1'b0,32'h10};
        vecs[4]  = '{2'b00,1'b1,4'h0,3'd1,4'h0,3'd3,32'h10,32'h0,16'hFFFF,16'h0,32'h0, 1'b1,32'hF,4'b0110,1'b0,32'h0};
        vecs[5]  = '{2'b01,1'b1,4'h8,3'd3,4'h0,3'd4,32'hF0F0F0F0,32'h0F0F0F0F,16'h0,16'h0,32'h0, 1'b1,32'h0,4'b0010,1'b0,32'h0};
        vecs[6]  = '{2'b01,1'b1,4'h8,3'd5,4'h0,3'd5,32'hFFFF0000,32'h00FF00FF,16'h0,16'h0,32'h0, 1'b1,32'hFF0000FF,4'b1000,1'b0,32'h0};
        vecs[7]  = '{2'b11,1'b0,4'h0,3'd0,4'h4,3'd0,32'h0,32'h0,16'h0,16'h0010,32'h200, 1'b0,32'h0,4'b1000,1'b1,32'h210};
        vecs[8]  = '{2'b11,1'b0,4'h0,3'd0,4'hA,3'd0,32'h0,32'h0,16'h0,16'h0,32'h200, 1'b0,32'h0,4'b1000,1'b0,32'h200};
        vecs[9]  = '{2'b01,1'b1,4'h8,3'd2,4'h0,3'd6,32'h80000000,32'h1,16'h0,16'h0,32'h0, 1'b1,32'h7FFFFFFF,4'b0101,1'b0,32'h0};
        vecs[10] = '{2'b11,1'b0,4'h0,3'd0,4'h8,3'd0,32'h0,32'h0,16'h0,16'h8000,32'h300, 1'b0,32'h0,4'b0101,1'b1,32'hFFFF8300};
        vecs[11] = '{2'b11,1'b0,4'h0,3'd0,4'hB,3'd0,32'h0,32'h0,16'h0,16'h0004,32'h0, 1'b0,32'h0,4'b0101,1'b1,32'h4};
        vecs[12] = '{2'b11,1'b0,4'h0,3'd0,4'hC,3'd0,32'h0,32'h0,16'h0,16'h0,32'h0, 1'b0,32'h0,4'b0101,1'b0,32'h0};
        vecs[13] = '{2'b11,1'b0,4'h0,3'd0,4'hF,3'd0,32'h0,32'h0,16'h0,16'h0004,32'h40, 1'b0,32'h0,4'b0101,1'b0,32'h44};
        vecs[14] = '{2'b00,1'b0,4'h8,3'd4,4'h0,3'd7,32'h1,32'h0,16'd32,16'h0,32'h0, 1'b1,32'h0,4'b0101,1'b0,32'h0};
        vecs[15] = '{2'b00,1'b0,4'h0,3'd1,4'h0,3'd1,32'h12345678,32'h0,16'hABCD,16'h0,32'h0, 1'b1,32'hABCD5678,4'b0101,1'b0,32'h0};
        vecs[16] = '{2'b00,1'b0,4'h0,3'd0,4'h0,3'd2,32'hFFFFFFFF,32'h0,16'h1234,16'h0,32'h0, 1'b1,32'hFFFF1234,4'b0101,1'b0,32'h0};
        vecs[17] = '{2'b00,1'b0,4'h0,3'd5,4'h0,3'd3,32'h80000000,32'h0,16'd31,16'h0,32'h0, 1'b1,32'h1,4'b0101,1'b0,32'h0};
        vecs[18] = '{2'b00,1'b0,4'h0,3'd4,4'h0,3'd4,32'h3,32'h0,16'd4,16'h0,32'h0, 1'b1,32'h30,4'b0101,1'b0,32'h0};
        vecs[19] = '{2'b00,1'b0,4'h0,3'd3,4'h0,3'd5,32'h0,32'h0,16'h0,16'h0,32'h0, 1'b1,32'hFFFFFFFF,4'b0101,1'b0,32'h0};
        vecs[20] = '{2'b00,1'b0,4'h0,3'd2,4'h0,3'd6,32'h12345678,32'h0,16'h0,16'h0,32'h0, 1'b1,32'h0,4'b0101,1'b0,32'h0};
        vecs[21] = '{2'b01,1'b1,4'h8,3'd0,4'h0,3'd1,32'h0,32'h0,16'h0,16'h0,32'h0, 1'b0,32'h0,4'b0101,1'b0,32'h0};
        vecs[22] = '{2'b01,1'b1,4'h8,3'd6,4'h0,3'd2,32'h0,32'h0,16'h0,16'h0,32'h0, 1'b1,32'hFFFFFFFF,4'b1000,1'b0,32'h0};
        vecs[23] = '{2'b01,1'b1,4'h8,3'd1,4'h0,3'd3,32'hFFFFFFFF,32'h1,16'h0,16'h0,32'h0, 1'b1,32'h0,4'b0110,1'b0,32'h0};
        vecs[24] = '{2'b11,1'b0,4'h0,3'd0,4'h2,3'd0,32'h0,32'h0,16'h0,16'h0100,32'h1000, 1'b0,32'h0,4'b0110,1'b1,32'h1100};
        vecs[25] = '{2'b11,1'b0,4'h0,3'd0,4'hE,3'd0,32'h0,32'h0,16'h0,16'hFF80,32'h80, 1'b0,32'h0,4'b0110,1'b1,32'h0};
        vecs[26] = '{2'b11,1'b0,4'h0,3'd0,4'h9,3'd0,32'h0,32'h0,16'h0,16'h0,32'h0, 1'b0,32'h0,4'b0110,1'b1,32'h0};
        vecs[27] = '{2'b00,1'b0,4'h0,3'd6,4'h0,3'd4,32'h5,32'h0,16'h0,16'h0,32'h0, 1'b0,32'h0,4'b0110,1'b0,32'h0};
        vecs[28] = '{2'b00,1'b0,4'h0,3'd4,4'h0,3'd5,32'h1,32'h0,16'd31,16'h0,32'h0, 1'b1,32'h80000000,4'b0110,1'b0,32'h0};
        vecs[29] = '{2'b00,1'b0,4'h0,3'd5,4'h0,3'd6,32'hFFFFFFFF,32'h0,16'hFFFF,16'h0,32'h0, 1'b1,32'h0,4'b0110,1'b0,32'h0};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ld, st;
        ld = '{2'b10,1'b0,4'h0,3'd0,4'h0,3'd5,32'h1000,32'h0,16'hFFF0,16'h0,32'h0, 1'b1,32'h0,4'b0,1'b0,32'h0};
        st = '{2'b10,1'b0,4'h1,3'd0,4'h0,3'd6,32'hCAFEF00D,32'h2000,16'h0004,16'h0,32'h0, 1'b0,32'h0,4'b0,1'b0,32'h0};

        // ---- reset state
        #12;
        check1("rst out_valid", out_valid, 1'b0);
        check1("rst in_ready", in_ready, 1'b0);
        check1("rst mem_req", mem_req, 1'b0);
        check1("rst mem_err", mem_err, 1'b0);
        check32("rst flags", 32'(flags), 32'h0);
        check32("rst wb_data", wb_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("post-rst in_ready", in_ready, 1'b1);

        // ---- table vectors
        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // ---- load, ack in the fourth request cycle
        issue(ld, "load");
        for (int i = 0; i < 4; i++) begin
            check1($sformatf("load c%0d mem_req", i), mem_req, 1'b1);
            check32($sformatf("load c%0d mem_addr", i), mem_addr, 32'h00000FF0);
            check1($sformatf("load c%0d mem_we", i), mem_we, 1'b0);
            check1($sformatf("load c%0d in_ready", i), in_ready, 1'b0);
            check1($sformatf("load c%0d out_valid", i), out_valid, 1'b0);
            @(negedge clk);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        check1("load out_valid", out_valid, 1'b1);
        check1("load mem_req dropped", mem_req, 1'b0);
        check1("load wb_sel", wb_sel, 1'b1);
        check1("load wb_en", wb_en, 1'b1);
        check32("load wb_data", wb_data, 32'hDEADBEEF);
        check32("load wb_reg", 32'(wb_reg), 32'd5);
        check1("load in_ready", in_ready, 1'b0);
        check1("load mem_err", mem_err, 1'b0);
        check32("load flags", 32'(flags), 32'b0110);

        // ---- store with no ack: timeout after TMO cycles
        issue(st, "store");
        for (int i = 0; i < TMO; i++) begin
            check1($sformatf("store c%0d mem_req", i), mem_req, 1'b1);
            check32($sformatf("store c%0d mem_addr", i), mem_addr, 32'h00002004);
            check32($sformatf("store c%0d mem_wdata", i), mem_wdata, 32'hCAFEF00D);
            check1($sformatf("store c%0d mem_we", i), mem_we, 1'b1);
            @(posedge clk);
            #1;
        end
        check1("store timeout mem_req", mem_req, 1'b0);
        check1("store timeout out_valid", out_valid, 1'b1);
        check1("store timeout wb_en", wb_en, 1'b0);
        check1("store timeout mem_err", mem_err, 1'b1);
        run_vec(vecs[0], 100);
        check1("mem_err sticky", mem_err, 1'b1);

        // ---- reset in the middle of a load
        issue(ld, "rstload");
        @(posedge clk);
        #3;
        check1("rstload pre mem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("rstload mem_req", mem_req, 1'b0);
        check32("rstload flags", 32'(flags), 32'h0);
        check1("rstload out_valid", out_valid, 1'b0);
        check1("rstload mem_err", mem_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check1($sformatf("rstload rel c%0d out_valid", i), out_valid, 1'b0);
            check1($sformatf("rstload rel c%0d in_ready", i), in_ready, 1'b1);
        end
        run_vec(vecs[5], 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
